// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: 2-flop synchronizer, per-bit stability counter, edge pulses.
// Sticky rising-edge capture with irq is built only when SWITCH_DEBOUNCER_EDGE_CAPTURE_EN is defined.
module switch_debouncer #(
    parameter int WIDTH        = 16,
    parameter int STABLE_COUNT = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    localparam int              CNT_W = $clog2(STABLE_COUNT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] count [WIDTH];
    logic [WIDTH-1:0] db_reg;
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] settle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // settle marks bits whose new level has now persisted for the full count
    always_comb begin
        differ = sync2 ^ db_reg;
        settle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            settle[i] = differ[i] && (count[i] == TERM);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i]) begin
                    count[i] <= '0;
                end else if (count[i] == TERM) begin
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_reg   <= '0;
            rise_reg <= '0;
            fall_reg <= '0;
        end else begin
            db_reg   <= (db_reg & ~settle) | (sync2 & settle);
            rise_reg <= settle & sync2;
            fall_reg <= settle & ~sync2;
        end
    end

    assign sw_db = db_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] capture_reg;

    // a new rising edge wins over a clear landing on the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture_reg <= '0;
        end else begin
            capture_reg <= (capture_reg & ~({WIDTH{clr_valid}} & clr_mask)) | rise_reg;
        end
    end

    assign edge_capture = capture_reg;
    assign irq          = |capture_reg;
`else
    logic unused_clr;

    assign unused_clr   = ^{clr_valid, clr_mask};
    assign edge_capture = '0;
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_COUNT=4, WIDTH=16.
// Edge-capture expectations follow SWITCH_DEBOUNCER_EDGE_CAPTURE_EN.
module tb_switch_debouncer;

    localparam int WIDTH = 16;
    localparam int STABLE_COUNT = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
    localparam bit EC_EN = 1'b1;
`else
    localparam bit EC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             clr_valid;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] edge_capture;
    logic             irq;

    int checks = 0;
    int failures = 0;

    switch_debouncer #(.WIDTH(WIDTH), .STABLE_COUNT(STABLE_COUNT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .rise(rise),
        .fall(fall),
        .clr_valid(clr_valid),
        .clr_mask(clr_mask),
        .edge_capture(edge_capture),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ecx(input logic [WIDTH-1:0] v);
        return EC_EN ? v : '0;
    endfunction

    function automatic logic [WIDTH-1:0] irqx(input logic [WIDTH-1:0] v);
        return {{(WIDTH-1){1'b0}}, EC_EN & (|v)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_sw_db"}, sw_db, '0);
        check({tag, "_rise"}, rise, '0);
        check({tag, "_fall"}, fall, '0);
        check({tag, "_edge_capture"}, edge_capture, '0);
        check({tag, "_irq"}, {{(WIDTH-1){1'b0}}, irq}, '0);
    endtask

    initial begin
        reset_n   = 1'b0;
        sw_raw    = '0;
        clr_valid = 1'b0;
        clr_mask  = '0;
        #2;
        check_all_zero("reset");
        step();
        step();
        reset_n = 1'b1;

        // bit 0 rises: sw_db changes on the 6th edge counting the sampling edge
        sw_raw = 16'h0001;
        repeat (5) step();
        check("b0_before_term", sw_db, 16'h0000);
        check("b0_no_early_rise", rise, 16'h0000);
        step();
        check("b0_sw_db", sw_db, 16'h0001);
        check("b0_rise", rise, 16'h0001);
        check("b0_fall", fall, 16'h0000);
        check("b0_ec_not_yet", edge_capture, 16'h0000);
        step();
        check("b0_rise_one_cycle", rise, 16'h0000);
        check("b0_ec_set", edge_capture, ecx(16'h0001));
        check("b0_irq_set", {15'b0, irq}, irqx(16'h0001));
        clr_valid = 1'b1;
        clr_mask  = 16'h0001;
        step();
        clr_valid = 1'b0;
        clr_mask  = '0;
        check("b0_ec_clr", edge_capture, 16'h0000);
        check("b0_irq_clr", {15'b0, irq}, 16'h0000);

        // bit 3 glitch: high only 3 cycles, never accepted
        sw_raw = 16'h0009;
        repeat (3) step();
        sw_raw = 16'h0001;
        for (int k = 0; k < 8; k++) begin
            check("glitch_sw_db", sw_db, 16'h0001);
            check("glitch_edges", rise | fall, 16'h0000);
            step();
        end

        // bit 3 held: full count again proves no partial credit
        sw_raw = 16'h0009;
        repeat (5) step();
        check("b3_before_term", sw_db, 16'h0001);
        step();
        check("b3_sw_db", sw_db, 16'h0009);
        check("b3_rise", rise, 16'h0008);
        sw_raw = 16'h0001;
        repeat (5) step();
        check("b3_hold_high", sw_db, 16'h0009);
        step();
        check("b3_fall_sw_db", sw_db, 16'h0001);
        check("b3_fall", fall, 16'h0008);
        check("b3_fall_no_rise", rise, 16'h0000);
        check("b3_ec", edge_capture, ecx(16'h0008));

        // bit 2 rises while a clear covering bits 2 and 3 lands on the capture edge
        sw_raw = 16'h0005;
        repeat (6) step();
        check("b2_sw_db", sw_db, 16'h0005);
        check("b2_rise", rise, 16'h0004);
        clr_valid = 1'b1;
        clr_mask  = 16'h000C;
        step();
        clr_valid = 1'b0;
        clr_mask  = '0;
        check("b2_set_wins", edge_capture, ecx(16'h0004));
        check("b2_irq", {15'b0, irq}, irqx(16'h0004));

        // reset two cycles into an all-ones transition
        sw_raw = 16'hFFFF;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        step();
        step();
        check("midreset_hold_sw_db", sw_db, 16'h0000);
        reset_n = 1'b1;
        repeat (5) step();
        check("post_reset_before_term", sw_db, 16'h0000);
        check("post_reset_no_rise", rise, 16'h0000);
        step();
        check("post_reset_sw_db", sw_db, 16'hFFFF);
        check("post_reset_rise", rise, 16'hFFFF);
        check("post_reset_fall", fall, 16'h0000);
        step();
        check("post_reset_rise_clear", rise, 16'h0000);
        check("post_reset_ec", edge_capture, ecx(16'hFFFF));

        // all bits fall together
        sw_raw = 16'h0000;
        repeat (6) step();
        check("all_fall_sw_db", sw_db, 16'h0000);
        check("all_fall", fall, 16'hFFFF);
        check("all_fall_no_rise", rise, 16'h0000);
        step();
        check("all_fall_one_cycle", fall, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
